// File: rtl/rt_pkg.sv
// Shared constants and segment-range helpers for the reduction-tree datapath.
// The carry-propagate adder uses them to split its carry chain into pipeline segments.
package rt_pkg;

  localparam int RT_W   = 32;
  localparam int RT_SEG = 8;

  function automatic int rt_nseg(input int w, input int seg);
    return w / seg;
  endfunction

  function automatic int rt_seg_lsb(input int k, input int seg);
    return k * seg;
  endfunction

  // The top segment also absorbs the two growth bits of sum + 2*carry.
  function automatic int rt_seg_width(input int k, input int nseg, input int seg);
    return (k == nseg - 1) ? seg + 2 : seg;
  endfunction

endpackage

// File: rtl/rt_cpa_seg.sv
// One carry-propagate stage: adds one operand segment plus carry-in and
// registers the sum segment, carry-out and valid bit under a shared enable.
module rt_cpa_seg #(
  parameter int SW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          in_vld,
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] sum,
  output logic          cout,
  output logic          vld
);

  logic [SW:0] add;

  assign add = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};

  always_ff @(posedge clk) begin
    if (rst) begin
      vld  <= 1'b0;
      cout <= 1'b0;
    end else if (en) begin
      vld  <= in_vld;
      cout <= add[SW];
    end
  end

  // Sum data carries no reset; it is qualified by vld downstream.
  always_ff @(posedge clk) begin
    if (en) sum <= add[SW-1:0];
  end

endmodule

// File: rtl/rt_final_cpa.sv
// Pipelined final carry-propagate adder: result = sum_vec + 2*carry_vec,
// resolved SEG bits per stage with skewed operands and a global stall.
module rt_final_cpa
  import rt_pkg::*;
#(
  parameter int W   = RT_W,
  parameter int SEG = RT_SEG
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] sum_vec,
  input  logic [W-1:0] carry_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W+1:0] result
);

  localparam int NSEG = rt_nseg(W, SEG);

  logic         en;
  logic [W+1:0] a_op;
  logic [W+1:0] b_op;
  logic [W+1:0] res_raw;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign a_op     = {2'b00, sum_vec};
  assign b_op     = {1'b0, carry_vec, 1'b0};

  for (genvar k = 0; k < NSEG; k++) begin : g_st
    localparam int LSB = rt_seg_lsb(k, SEG);
    localparam int SW  = rt_seg_width(k, NSEG, SEG);
    localparam int UW  = W + 2 - LSB - SW;

    logic [SW-1:0] a_seg;
    logic [SW-1:0] b_seg;
    logic [SW-1:0] s;
    logic          cin;
    logic          vld_in;
    logic          cout;
    logic          vld;

    if (k == 0) begin : g_src
      assign a_seg  = a_op[SW-1:0];
      assign b_seg  = b_op[SW-1:0];
      assign cin    = 1'b0;
      assign vld_in = in_valid;
    end else begin : g_src
      assign a_seg  = g_st[k-1].g_fwd.a_q[SW-1:0];
      assign b_seg  = g_st[k-1].g_fwd.b_q[SW-1:0];
      assign cin    = g_st[k-1].cout;
      assign vld_in = g_st[k-1].vld;
    end

    rt_cpa_seg #(.SW(SW)) u_seg (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .in_vld (vld_in),
      .a      (a_seg),
      .b      (b_seg),
      .cin    (cin),
      .sum    (s),
      .cout   (cout),
      .vld    (vld)
    );

    // Skew: operand bits above this segment move forward one stage per enable.
    if (UW > 0) begin : g_fwd
      logic [UW-1:0] a_q;
      logic [UW-1:0] b_q;
      if (k == 0) begin : g_ld
        always_ff @(posedge clk) begin
          if (en) begin
            a_q <= a_op[W+1:SW];
            b_q <= b_op[W+1:SW];
          end
        end
      end else begin : g_ld
        always_ff @(posedge clk) begin
          if (en) begin
            a_q <= g_st[k-1].g_fwd.a_q[UW+SW-1:SW];
            b_q <= g_st[k-1].g_fwd.b_q[UW+SW-1:SW];
          end
        end
      end
    end

    // Already-resolved lower result segments travel alongside.
    if (k > 0) begin : g_res
      logic [LSB-1:0] res_q;
      if (k == 1) begin : g_ld
        always_ff @(posedge clk) begin
          if (en) res_q <= g_st[0].s;
        end
      end else begin : g_ld
        always_ff @(posedge clk) begin
          if (en) res_q <= {g_st[k-1].s, g_st[k-1].g_res.res_q};
        end
      end
    end

    // The top carry-out is zero for any legal operand pair.
    if (k == NSEG - 1) begin : g_top
      always_ff @(posedge clk) begin
        if (!rst && vld) assert (!cout);
      end
    end
  end

  if (NSEG > 1) begin : g_out
    assign res_raw = {g_st[NSEG-1].s, g_st[NSEG-1].g_res.res_q};
  end else begin : g_out
    assign res_raw = g_st[0].s;
  end

  assign out_valid = g_st[NSEG-1].vld;
  assign result    = out_valid ? res_raw : '0;

endmodule

// File: tb/tb_rt_final_cpa.sv
// Randomized scoreboard bench for rt_final_cpa: expected results are plain
// sum + 2*carry arithmetic, with latency, stall-stability and reset checks.
module tb_rt_final_cpa;

  localparam int W    = 32;
  localparam int NSEG = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] sum_vec;
  logic [W-1:0] carry_vec;
  logic         out_valid;
  logic         out_ready;
  logic [W+1:0] result;

  rt_final_cpa dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_vec   (sum_vec),
    .carry_vec (carry_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W+1:0] v;
    int           acc;
    bit           lat;
  } item_t;

  item_t        q[$];
  int           total = 0;
  int           bad = 0;
  int           cyc_n = 0;
  bit           prev_stall = 1'b0;
  logic [W+1:0] prev_res;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  // Drive one cycle of inputs, check outputs, update the scoreboard.
  task automatic cyc(input bit iv, input logic [W-1:0] s, input logic [W-1:0] c, input bit ordy);
    item_t it;
    logic [W+1:0] model;
    in_valid  = iv;
    sum_vec   = s;
    carry_vec = c;
    out_ready = ordy;
    #1;
    chk("in_ready", 64'(in_ready), 64'(!out_valid || ordy));
    if (prev_stall) begin
      chk("stall_vld", 64'(out_valid), 64'd1);
      chk("stall_res", 64'(result), 64'(prev_res));
    end
    if (out_valid && ordy) begin
      if (q.size() == 0) begin
        chk("spurious", 64'(out_valid), 64'd0);
      end else begin
        it = q.pop_front();
        chk("result", 64'(result), 64'(it.v));
        if (it.lat) chk("latency", 64'(cyc_n - it.acc), 64'(NSEG));
      end
    end
    prev_stall = out_valid && !ordy;
    prev_res   = result;
    if (iv && in_ready) begin
      model = (W+2)'(s) + (W+2)'(c) * 2;
      q.push_back('{v: model, acc: cyc_n, lat: 1'b1});
    end
    if (!ordy) foreach (q[i]) q[i].lat = 1'b0;
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic idle(input int n, input bit ordy);
    repeat (n) cyc(1'b0, W'($urandom), W'($urandom), ordy);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    cyc_n++;
    rst = 1'b0;
    #1;
    chk("rst_vld", 64'(out_valid), 64'd0);
    chk("rst_res", 64'(result), 64'd0);
    chk("rst_rdy", 64'(in_ready), 64'd1);
    q.delete();
    prev_stall = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sum_vec   = '0;
    carry_vec = '0;
    repeat (2) @(negedge clk);
    do_reset();

    cyc(1'b1, 32'h0000_0003, 32'h0000_0002, 1'b1);
    idle(6, 1'b1);
    cyc(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    idle(6, 1'b1);
    cyc(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    idle(6, 1'b1);

    for (int i = 0; i < 8; i++) cyc(1'b1, W'($urandom), W'($urandom), 1'b1);
    idle(6, 1'b1);

    for (int i = 0; i < 12; i++) cyc(1'b1, W'($urandom), W'($urandom), 1'b0);
    idle(10, 1'b1);
    chk("bp_drain", 64'(q.size()), 64'd0);

    for (int i = 0; i < 3; i++) cyc(1'b1, W'($urandom), W'($urandom), 1'b1);
    do_reset();
    cyc(1'b1, W'($urandom), W'($urandom), 1'b1);
    idle(6, 1'b1);

    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] s;
      logic [W-1:0] c;
      s = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
      c = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
      cyc($urandom_range(0, 3) != 0, s, c, $urandom_range(0, 3) != 0);
    end
    idle(10, 1'b1);
    chk("final_drain", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
